// File: rtl/countdown_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : countdown_sequencer_if
// Description : Control and status bundle for countdown_sequencer.
//               master : driver of start/load_val/pause/abort/auto_reload,
//                        observer of the status outputs.
//               slave  : the sequencer itself.
//   start       request to load load_val and begin counting
//   load_val    start value / reload period (WIDTH bits)
//   pause       level, hold the count while high
//   abort       level, cancel the current countdown
//   auto_reload level, restart from the stored period on expiry
//   count_out   current down-counter value
//   state_out   0 IDLE, 1 RUN, 2 HOLD, 3 DONE
//   busy        RUN or HOLD
//   done        high for the single DONE cycle of each expiry
//   err         one-cycle pulse after a rejected start
//   periods     expiries since reset / last accepted start, saturating
// Revision    : 1.0 - initial release
// ============================================================================
interface countdown_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             pause;
    logic             abort;
    logic             auto_reload;
    logic [WIDTH-1:0] count_out;
    logic [1:0]       state_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [7:0]       periods;

    modport master (
        output start, load_val, pause, abort, auto_reload,
        input  count_out, state_out, busy, done, err, periods
    );

    modport slave (
        input  start, load_val, pause, abort, auto_reload,
        output count_out, state_out, busy, done, err, periods
    );
endinterface
`default_nettype wire

// File: rtl/countdown_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_sequencer
// Description : Loadable down-counter with pause, abort, auto-reload and an
//               expiry counter. Every status output is a register or a
//               decode of the state register.
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    countdown_sequencer_if.slave (control in, status out)
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_sequencer #(
    parameter int WIDTH = 8
) (
    input  wire                   clock,
    input  wire                   reset,
    countdown_sequencer_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [7:0]       c_per_max = 8'hFF;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic [7:0]       r_periods;
    logic             r_err;

    logic w_start_ok;
    logic w_accept;
    logic w_reject;
    logic w_abort;
    logic w_reload;
    logic w_expire;
    logic w_dec;
    logic w_busy;
    logic w_done;

    assign w_start_ok = bus.start && (bus.load_val != '0);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath-action decode. Abort in an active state wins
    // over everything, so a start arriving with it is neither taken nor
    // flagged.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_abort      = 1'b0;
        w_reload     = 1'b0;
        w_expire     = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end else if (bus.start) begin
                    w_reject = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_reject = bus.start;
                    if (bus.pause) begin
                        w_next_state = S_HOLD;
                    end else if (r_count <= c_one) begin
                        // <= rather than == keeps a zero count from wrapping
                        w_expire     = 1'b1;
                        w_next_state = S_DONE;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (bus.abort) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_reject = bus.start;
                    // Leaving HOLD costs one edge with no decrement.
                    if (!bus.pause) begin
                        w_next_state = S_RUN;
                    end
                end
            end
            default: begin // S_DONE
                if (bus.abort) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_start_ok) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_reject = bus.start;
                    if (bus.auto_reload) begin
                        w_reload     = 1'b1;
                        w_next_state = S_RUN;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
        endcase
    end

    // Output decode from the state register
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN,
            S_HOLD:  w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= '0;
            r_period  <= '0;
            r_periods <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_abort) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count   <= bus.load_val;
                r_period  <= bus.load_val;
                r_periods <= '0;
            end else if (w_reload) begin
                r_count <= r_period;
            end else if (w_expire) begin
                r_count <= '0;
                if (r_periods != c_per_max) begin
                    r_periods <= r_periods + 8'd1;
                end
            end else if (w_dec) begin
                r_count <= r_count - c_one;
            end
        end
    end

    assign bus.count_out = r_count;
    assign bus.state_out = r_state;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.err       = r_err;
    assign bus.periods   = r_periods;

endmodule
`default_nettype wire
